// File: rtl/alien_pkg.sv
// Shared types and constants for the alien collision arbiter and its score counter.
package alien_pkg;

  typedef enum logic [0:0] {
    ALIVE = 1'b0,
    DEAD  = 1'b1
  } alien_hit_state_t;

  localparam int          SCORE_PER_ALIEN = 25;
  localparam logic [15:0] SCORE_MAX       = 16'h9999;

  // Binary to 4-digit packed BCD, evaluated at elaboration for constant increments.
  function automatic logic [15:0] to_bcd4(input int unsigned value);
    int unsigned v;
    logic [15:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// 4-digit BCD accumulator: adds a constant BCD increment per add pulse, saturating at SCORE_MAX.
module bcd_score_counter
  import alien_pkg::*;
#(
  parameter logic [15:0] INC_BCD = 16'h0025
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_i,
  output logic [15:0] score_o
);

  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [15:0] sum;
  logic [4:0]  digit;
  logic        carry;

  always_comb begin
    sum   = '0;
    digit = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit = 5'(score_q[i*4 +: 4]) + 5'(INC_BCD[i*4 +: 4]) + 5'(carry);
      if (digit > 5'd9) begin
        digit = digit - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[i*4 +: 4] = digit[3:0];
    end
    // A carry out of the thousands digit means the total passed 9999.
    score_d = score_q;
    if (add_i) begin
      score_d = carry ? SCORE_MAX : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/alien_hit_ctrl.sv
// Per-frame alien/player/shot collision arbiter with respawn timer and player grace window.
// Optional BCD score output enabled by defining ALIEN_HIT_SCORE_EN.
module alien_hit_ctrl
  import alien_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 120,
  parameter int GRACE_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        alien_dr,
  input  logic        player_dr,
  input  logic        shot_dr,
  output logic        alien_died,
  output logic        player_died,
  output logic        alien_respawn,
  output logic        alien_alive
`ifdef ALIEN_HIT_SCORE_EN
  ,
  output logic [15:0] score
`endif
);

  localparam int RW = $clog2(RESPAWN_FRAMES + 1);
  // A zero grace window would give a zero-width counter, so keep at least one bit.
  localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [RW-1:0] RESPAWN_LOAD = RW'(RESPAWN_FRAMES);
  localparam logic [GW-1:0] GRACE_LOAD   = GW'(GRACE_FRAMES);

  alien_hit_state_t state_q;
  logic             hit_shot_q, hit_player_q;
  logic             hit_shot_d, hit_player_d;
  logic [RW-1:0]    respawn_cnt_q;
  logic [GW-1:0]    grace_cnt_q;
  logic             alien_died_q, player_died_q, alien_respawn_q;
  logic             shot_ovl, player_ovl, kill_now;

  assign shot_ovl   = alien_dr & shot_dr;
  assign player_ovl = alien_dr & player_dr;
  assign kill_now   = startOfFrame && (state_q == ALIVE) && hit_shot_q;

  // On a frame boundary the flags restart from this cycle's overlap.
  assign hit_shot_d   = startOfFrame ? shot_ovl   : (hit_shot_q   | shot_ovl);
  assign hit_player_d = startOfFrame ? player_ovl : (hit_player_q | player_ovl);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ALIVE;
      hit_shot_q      <= 1'b0;
      hit_player_q    <= 1'b0;
      respawn_cnt_q   <= '0;
      grace_cnt_q     <= '0;
      alien_died_q    <= 1'b0;
      player_died_q   <= 1'b0;
      alien_respawn_q <= 1'b0;
    end else begin
      alien_died_q    <= 1'b0;
      player_died_q   <= 1'b0;
      alien_respawn_q <= 1'b0;
      hit_shot_q      <= hit_shot_d;
      hit_player_q    <= hit_player_d;
      if (startOfFrame) begin
        if (grace_cnt_q != '0) begin
          grace_cnt_q <= grace_cnt_q - 1'b1;
        end
        unique case (state_q)
          ALIVE: begin
            if (kill_now) begin
              alien_died_q  <= 1'b1;
              respawn_cnt_q <= RESPAWN_LOAD;
              state_q       <= DEAD;
            end else if (hit_player_q && (grace_cnt_q == '0)) begin
              player_died_q <= 1'b1;
              grace_cnt_q   <= GRACE_LOAD;
            end
          end
          DEAD: begin
            if (respawn_cnt_q != '0) begin
              respawn_cnt_q <= respawn_cnt_q - 1'b1;
            end
            // Overlaps seen while dead must not leak into the first live frame.
            if (respawn_cnt_q == RW'(1)) begin
              alien_respawn_q <= 1'b1;
              state_q         <= ALIVE;
              hit_shot_q      <= 1'b0;
              hit_player_q    <= 1'b0;
            end
          end
          default: state_q <= ALIVE;
        endcase
      end
    end
  end

  assign alien_died    = alien_died_q;
  assign player_died   = player_died_q;
  assign alien_respawn = alien_respawn_q;
  assign alien_alive   = (state_q == ALIVE);

`ifdef ALIEN_HIT_SCORE_EN
  bcd_score_counter #(
    .INC_BCD(to_bcd4(SCORE_PER_ALIEN))
  ) u_score (
    .clk    (clk),
    .reset  (reset),
    .add_i  (kill_now),
    .score_o(score)
  );
`endif

endmodule
